// File: rtl/argmax_pkg.sv
// Shared definitions for the argmax frame controller: FSM encoding, default
// geometry and the helpers used to size and sanity-check a configuration.
package argmax_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_DEF = 8;
  localparam int K_DEF = 100;
  localparam int M_DEF = 10;

  // Width of a counter/index over k items, never narrower than one bit.
  function automatic int idx_w(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

  function automatic bit cfg_ok(input int k, input int m);
    return (k >= 2) && (m >= 1) && (m <= k) && ((k % m) == 0);
  endfunction

endpackage

// File: rtl/argmax_ctrl_argmax.sv
// Combinational argmax over K packed signed lanes; the lowest lane index wins
// among equal maxima because only a strictly greater lane replaces the leader.
module argmax #(
  parameter  int K  = 10,
  parameter  int N  = 8,
  localparam int LW = (K > 1) ? $clog2(K) : 1
) (
  input  logic [K*N-1:0]        data,
  output logic [LW-1:0]         idx,
  output logic signed [N-1:0]   max_val
);

  always_comb begin
    max_val = $signed(data[N-1:0]);
    idx     = '0;
    for (int i = 1; i < K; i++) begin
      if ($signed(data[i*N +: N]) > max_val) begin
        max_val = $signed(data[i*N +: N]);
        idx     = LW'(i);
      end
    end
  end

endmodule

// File: rtl/argmax_ctrl.sv
// Frame controller: buffers K samples, scans them M lanes per cycle through the
// argmax datapath keeping a running maximum, then offers index and value.
module argmax_ctrl
  import argmax_pkg::*;
#(
  parameter  int N    = N_DEF,
  parameter  int K    = K_DEF,
  parameter  int M    = M_DEF,
  localparam int IDXW = $clog2(K)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic signed [N-1:0]    in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [IDXW-1:0]        out_index_o,
  output logic signed [N-1:0]    out_max_o,
  output logic                   busy_o
);

  localparam int CHUNKS = K / M;
  localparam int CW     = idx_w(CHUNKS);
  localparam int LW     = idx_w(M);

  if (!cfg_ok(K, M)) begin : g_cfg_check
    $error("argmax_ctrl: need K >= 2, 1 <= M <= K and M dividing K");
  end

  state_t                state;
  logic [IDXW-1:0]       ptr;
  logic [CW-1:0]         c;
  logic signed [N-1:0]   mem [K];
  logic signed [N-1:0]   best, new_best, lane_max;
  logic [IDXW-1:0]       best_idx, new_idx, base, gidx;
  logic [M*N-1:0]        chunk;
  logic [LW-1:0]         lane_idx;
  logic                  accept, last_chunk;

  assign in_ready_o = (state == LOAD);
  assign accept     = in_valid_i && in_ready_o && !clear_i;
  assign last_chunk = (c == CW'(CHUNKS - 1));
  assign base       = IDXW'(int'(c) * M);
  assign gidx       = base + IDXW'(lane_idx);

  always_comb begin
    chunk = '0;
    for (int j = 0; j < M; j++) chunk[j*N +: N] = mem[base + IDXW'(j)];
  end

  argmax #(.K(M), .N(N)) u_argmax (
    .data    (chunk),
    .idx     (lane_idx),
    .max_val (lane_max)
  );

  // Strict compare keeps the earlier chunk on ties; chunk 0 always seeds.
  always_comb begin
    new_best = best;
    new_idx  = best_idx;
    if (c == '0 || lane_max > best) begin
      new_best = lane_max;
      new_idx  = gidx;
    end
  end

  // Sample buffer and running maximum are data only; no reset needed.
  always_ff @(posedge clk_i) begin
    if (accept) mem[ptr] <= in_data_i;
    if (state == EVAL) begin
      best     <= new_best;
      best_idx <= new_idx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= LOAD;
      ptr         <= '0;
      c           <= '0;
      out_valid_o <= 1'b0;
      out_index_o <= '0;
      out_max_o   <= '0;
      busy_o      <= 1'b0;
    end else if (clear_i) begin
      state       <= LOAD;
      ptr         <= '0;
      c           <= '0;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        LOAD: if (in_valid_i) begin
          if (ptr == IDXW'(K - 1)) begin
            ptr    <= '0;
            state  <= EVAL;
            busy_o <= 1'b1;
          end else begin
            ptr <= ptr + IDXW'(1);
          end
        end
        EVAL: if (last_chunk) begin
          c           <= '0;
          state       <= DONE;
          out_valid_o <= 1'b1;
          out_index_o <= new_idx;
          out_max_o   <= new_best;
        end else begin
          c <= c + CW'(1);
        end
        DONE: if (out_ready_i) begin
          state       <= LOAD;
          out_valid_o <= 1'b0;
          busy_o      <= 1'b0;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_ctrl.sv
// Directed bench for argmax_ctrl: instance 0 uses M=10, instance 1 M=K, instance 2 M=1.
module tb_argmax_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic signed [7:0] in_data = '0;
  logic vld [3];
  logic ordy [3];
  logic in_rdy [3];
  logic out_vld [3];
  logic busy [3];
  logic [6:0] oidx [3];
  logic signed [7:0] omax [3];
  logic signed [7:0] frame [100];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  argmax_ctrl #(.N(8), .K(100), .M(10)) u_m10 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .in_valid_i(vld[0]), .in_ready_o(in_rdy[0]),
    .in_data_i(in_data), .out_valid_o(out_vld[0]), .out_ready_i(ordy[0]), .out_index_o(oidx[0]),
    .out_max_o(omax[0]), .busy_o(busy[0]));

  argmax_ctrl #(.N(8), .K(100), .M(100)) u_m100 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .in_valid_i(vld[1]), .in_ready_o(in_rdy[1]),
    .in_data_i(in_data), .out_valid_o(out_vld[1]), .out_ready_i(ordy[1]), .out_index_o(oidx[1]),
    .out_max_o(omax[1]), .busy_o(busy[1]));

  argmax_ctrl #(.N(8), .K(100), .M(1)) u_m1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .in_valid_i(vld[2]), .in_ready_o(in_rdy[2]),
    .in_data_i(in_data), .out_valid_o(out_vld[2]), .out_ready_i(ordy[2]), .out_index_o(oidx[2]),
    .out_max_o(omax[2]), .busy_o(busy[2]));

  function automatic void ref_argmax(output int idx, output logic signed [7:0] mx);
    idx = 0;
    mx  = frame[0];
    for (int i = 1; i < 100; i++) begin
      if (frame[i] > mx) begin
        mx  = frame[i];
        idx = i;
      end
    end
  endfunction

  // Ends on the negedge after the last acceptance edge, with valid dropped.
  task automatic send_frame(input int sel, input int n);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < n && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (in_rdy[sel]) begin
        in_data = frame[i];
        vld[sel] = 1'b1;
        i++;
      end else begin
        vld[sel] = 1'b0;
      end
    end
    @(negedge clk);
    vld[sel] = 1'b0;
    checks++;
    if (i != n) begin
      errors++;
      $display("FAIL send_frame[%0d]: accepted %0d samples, required %0d", sel, i, n);
    end
  endtask

  task automatic wait_result(input int sel, output int lat);
    lat = 0;
    while (!out_vld[sel] && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume(input int sel);
    ordy[sel] = 1'b1;
    @(negedge clk);
    ordy[sel] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_rdy[0] !== 1'b1 || out_vld[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, required 1 0 0", in_rdy[0], out_vld[0], busy[0]);
    end
    checks++;
    if (oidx[0] !== 7'd0 || omax[0] !== 8'sd0) begin
      errors++;
      $display("FAIL reset_data: index=%0d max=%0d, required 0 0", oidx[0], omax[0]);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    for (int i = 0; i < 100; i++) frame[i] = 8'(i - 50);
    send_frame(0, 100);
    checks++;
    if (out_vld[0] !== 1'b0 || busy[0] !== 1'b1 || in_rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_eval: out_valid=%b busy=%b in_ready=%b, required 0 1 0", out_vld[0], busy[0], in_rdy[0]);
    end
    wait_result(0, lat);
    checks++;
    if (lat != 10) begin
      errors++;
      $display("FAIL basic_latency: %0d cycles, required 10", lat);
    end
    checks++;
    if (oidx[0] !== 7'd99 || omax[0] !== 8'sd49) begin
      errors++;
      $display("FAIL basic_result: index=%0d max=%0d, required 99 49", oidx[0], omax[0]);
    end
    consume(0);
    checks++;
    if (out_vld[0] !== 1'b0 || in_rdy[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_handshake: out_valid=%b in_ready=%b busy=%b, required 0 1 0", out_vld[0], in_rdy[0], busy[0]);
    end
  endtask

  task automatic test_signed();
    int lat;
    for (int i = 0; i < 100; i++) frame[i] = -8'sd1;
    frame[57] = 8'sd3;
    frame[12] = 8'h80;
    send_frame(0, 100);
    wait_result(0, lat);
    checks++;
    if (out_vld[0] !== 1'b1 || oidx[0] !== 7'd57 || omax[0] !== 8'sd3) begin
      errors++;
      $display("FAIL signed_neg: valid=%b index=%0d max=%0d, required 1 57 3", out_vld[0], oidx[0], omax[0]);
    end
    consume(0);
    for (int i = 0; i < 100; i++) frame[i] = -8'sd1;
    frame[0] = 8'h7F;
    send_frame(0, 100);
    wait_result(0, lat);
    checks++;
    if (out_vld[0] !== 1'b1 || oidx[0] !== 7'd0 || omax[0] !== 8'sd127) begin
      errors++;
      $display("FAIL signed_max_first: valid=%b index=%0d max=%0d, required 1 0 127", out_vld[0], oidx[0], omax[0]);
    end
    consume(0);
    for (int i = 0; i < 100; i++) frame[i] = 8'h80;
    send_frame(0, 100);
    wait_result(0, lat);
    checks++;
    if (out_vld[0] !== 1'b1 || oidx[0] !== 7'd0 || omax[0] !== -8'sd128) begin
      errors++;
      $display("FAIL signed_all_min: valid=%b index=%0d max=%0d, required 1 0 -128", out_vld[0], oidx[0], omax[0]);
    end
    consume(0);
  endtask

  task automatic test_ties();
    int lat;
    for (int i = 0; i < 100; i++) frame[i] = 8'sd5;
    send_frame(0, 100);
    wait_result(0, lat);
    checks++;
    if (out_vld[0] !== 1'b1 || oidx[0] !== 7'd0 || omax[0] !== 8'sd5) begin
      errors++;
      $display("FAIL ties_all_equal: valid=%b index=%0d max=%0d, required 1 0 5", out_vld[0], oidx[0], omax[0]);
    end
    consume(0);
    for (int i = 0; i < 100; i++) frame[i] = 8'(int'($urandom_range(0, 227)) - 128);
    frame[23] = 8'sd100;
    frame[81] = 8'sd100;
    send_frame(0, 100);
    wait_result(0, lat);
    checks++;
    if (out_vld[0] !== 1'b1 || oidx[0] !== 7'd23 || omax[0] !== 8'sd100) begin
      errors++;
      $display("FAIL ties_cross_chunk: valid=%b index=%0d max=%0d, required 1 23 100", out_vld[0], oidx[0], omax[0]);
    end
    consume(0);
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    for (int i = 0; i < 100; i++) frame[i] = 8'((i % 50) - 25);
    frame[64] = 8'sd120;
    send_frame(0, 100);
    wait_result(0, lat);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      vld[0] = (k % 3 == 0);
      in_data = 8'sd127;
      @(negedge clk);
      if (out_vld[0] !== 1'b1 || oidx[0] !== 7'd64 || omax[0] !== 8'sd120 || in_rdy[0] !== 1'b0 || busy[0] !== 1'b1)
        bad++;
    end
    vld[0] = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL backpressure_hold: %0d unstable cycles, required 0 (last index=%0d max=%0d)", bad, oidx[0], omax[0]);
    end
    consume(0);
    checks++;
    if (out_vld[0] !== 1'b0 || in_rdy[0] !== 1'b1 || oidx[0] !== 7'd64 || omax[0] !== 8'sd120) begin
      errors++;
      $display("FAIL backpressure_release: valid=%b in_ready=%b index=%0d max=%0d, required 0 1 64 120",
               out_vld[0], in_rdy[0], oidx[0], omax[0]);
    end
    for (int i = 0; i < 100; i++) frame[i] = 8'(40 - i);
    send_frame(0, 100);
    wait_result(0, lat);
    checks++;
    if (out_vld[0] !== 1'b1 || oidx[0] !== 7'd0 || omax[0] !== 8'sd40) begin
      errors++;
      $display("FAIL backpressure_next: valid=%b index=%0d max=%0d, required 1 0 40", out_vld[0], oidx[0], omax[0]);
    end
    consume(0);
  endtask

  task automatic test_abort();
    int lat;
    int bad;
    // clear mid-LOAD, with a sample presented in the clear cycle
    for (int i = 0; i < 100; i++) frame[i] = 8'(i - 50);
    frame[30] = 8'sd100;
    send_frame(0, 37);
    clear = 1'b1;
    vld[0] = 1'b1;
    in_data = 8'sd127;
    @(negedge clk);
    clear = 1'b0;
    vld[0] = 1'b0;
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_vld[0] !== 1'b0 || in_rdy[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_load_idle: %0d bad cycles, required 0", bad);
    end
    send_frame(0, 100);
    wait_result(0, lat);
    checks++;
    if (lat != 10 || oidx[0] !== 7'd30 || omax[0] !== 8'sd100) begin
      errors++;
      $display("FAIL clear_load_next: latency=%0d index=%0d max=%0d, required 10 30 100", lat, oidx[0], omax[0]);
    end
    consume(0);
    // clear during EVAL at chunk 4
    send_frame(0, 100);
    repeat (4) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (out_vld[0] !== 1'b0 || in_rdy[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL clear_eval_state: valid=%b in_ready=%b busy=%b, required 0 1 0", out_vld[0], in_rdy[0], busy[0]);
    end
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_vld[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_eval_no_output: %0d cycles with valid, required 0", bad);
    end
    for (int i = 0; i < 100; i++) frame[i] = 8'(i % 7);
    frame[88] = 8'sd9;
    send_frame(0, 100);
    wait_result(0, lat);
    checks++;
    if (out_vld[0] !== 1'b1 || oidx[0] !== 7'd88 || omax[0] !== 8'sd9) begin
      errors++;
      $display("FAIL clear_eval_next: valid=%b index=%0d max=%0d, required 1 88 9", out_vld[0], oidx[0], omax[0]);
    end
    // asynchronous reset while DONE
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_vld[0] !== 1'b0 || busy[0] !== 1'b0 || in_rdy[0] !== 1'b1 || oidx[0] !== 7'd0 || omax[0] !== 8'sd0) begin
      errors++;
      $display("FAIL reset_done: valid=%b busy=%b in_ready=%b index=%0d max=%0d, required 0 0 1 0 0",
               out_vld[0], busy[0], in_rdy[0], oidx[0], omax[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) frame[i] = 8'(-i);
    frame[99] = 8'sd1;
    send_frame(0, 100);
    wait_result(0, lat);
    checks++;
    if (out_vld[0] !== 1'b1 || oidx[0] !== 7'd99 || omax[0] !== 8'sd1) begin
      errors++;
      $display("FAIL reset_next: valid=%b index=%0d max=%0d, required 1 99 1", out_vld[0], oidx[0], omax[0]);
    end
    consume(0);
  endtask

  task automatic test_sweep(input int sel, input int exp_lat);
    int lat;
    int ridx;
    logic signed [7:0] rmax;
    int bad;
    bad = 0;
    for (int f = 0; f < 100; f++) begin
      for (int i = 0; i < 100; i++)
        frame[i] = (f % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'(int'($urandom_range(0, 4)) - 2);
      ref_argmax(ridx, rmax);
      send_frame(sel, 100);
      wait_result(sel, lat);
      if (lat != exp_lat || out_vld[sel] !== 1'b1 || oidx[sel] !== 7'(ridx) || omax[sel] !== rmax) begin
        bad++;
        if (bad <= 3)
          $display("  sweep sel=%0d frame %0d: latency=%0d index=%0d max=%0d, expected %0d %0d %0d",
                   sel, f, lat, oidx[sel], omax[sel], exp_lat, ridx, rmax);
      end
      consume(sel);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sweep_sel%0d: %0d bad frames of 100, required 0", sel, bad);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0;
      ordy[i] = 1'b0;
    end
    test_reset();
    test_basic();
    test_signed();
    test_ties();
    test_backpressure();
    test_abort();
    test_sweep(1, 1);
    test_sweep(2, 100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/argmax_ctrl.md
Name: argmax_ctrl

Overview:
Sequential controller that collects a frame of K signed N-bit samples over a valid/ready stream into a local buffer. It sequences a combinational argmax datapath of M lanes across the buffer in K/M chunks, keeping a running maximum. It then presents the winning index and value on a valid/ready output. It sits between a sample producer (for example a classifier score stream) and a consumer of the decision index.

Parameters:
N, 8, sample width in bits; samples are two's-complement signed.
K, 100, samples per frame; K >= 2.
M, 10, argmax lanes evaluated per cycle; 1 <= M <= K; K mod M == 0.
IDXW, $clog2(K), index width (localparam, derived).

Ports:
clk_i  in  1  clock, rising edge.
rst_ni  in  1  asynchronous, active-low reset.
clear_i  in  1  synchronous abort of the current frame.
in_valid_i  in  1  sample valid.
in_ready_o  out  1  controller accepts a sample this cycle.
in_data_i  in  N  signed sample.
out_valid_o  out  1  result valid.
out_ready_i  in  1  consumer accepts the result.
out_index_o  out  IDXW  index of the maximum (0 = first sample of the frame).
out_max_o  out  N  signed maximum value.
busy_o  out  1  high in EVAL or DONE.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values: state=LOAD, write pointer=0, chunk counter=0, out_valid_o=0, out_index_o=0, out_max_o=0, busy_o=0. in_ready_o=1, because it is decoded as state==LOAD.
- FSM states: LOAD, EVAL, DONE.
- LOAD:
  - in_ready_o=1.
  - On in_valid_i&&in_ready_o, write buf[ptr] and increment ptr.
  - On accepting sample K-1: ptr returns to 0 and the next state is EVAL.
- EVAL:
  - in_ready_o=0.
  - Chunk counter c runs 0..K/M-1, one chunk per cycle.
  - Each cycle, buf[c*M .. c*M+M-1] drives the argmax sub-module, which returns local index l.
  - The candidate is v = buf[c*M+l], at global index c*M+l, computed in IDXW bits without overflow.
  - Running-max update: if c==0 or v > best (signed, strict), then best<=v and best_idx<=c*M+l.
  - After the chunk K/M-1 update, the next state is DONE. c resets to 0.
- DONE:
  - out_valid_o=1; out_index_o=best_idx and out_max_o=best, both held stable.
  - in_ready_o=0; in_valid_i is ignored.
  - On out_valid_o&&out_ready_i, the next state is LOAD and out_valid_o=0 the next cycle.
  - out_index_o and out_max_o retain their last values until the next result.
- Latency:
  - The last sample is accepted at edge t. EVAL occupies cycles t+1..t+K/M.
  - out_valid_o rises in cycle t+K/M+1; for the defaults, that is t+11.
  - After the output handshake, in_ready_o=1 the next cycle.
- Tie rule: the lowest global index wins. The argmax sub-module returns the lowest lane index among equal maxima. Across chunks the strict > keeps the earlier chunk.
- Signedness: all comparisons are signed; 8'h80 (-128) is the minimum and 8'h7F (+127) the maximum.
- clear_i:
  - Has priority over all other transitions in every state.
  - Next state is LOAD; ptr=0, c=0, out_valid_o=0.
  - A partial frame is discarded and no result is produced.
  - A sample presented in the same cycle as clear_i is dropped.
- Reset mid-operation: asynchronous return to the reset values above from any state.
- M==K: EVAL lasts exactly 1 cycle.
- M==1: EVAL lasts K cycles; the sub-module degenerates to passing the sample through with l=0.

Decomposition:
- Shared package/header argmax_pkg:
  - FSM state encoding (LOAD, EVAL, DONE).
  - Default N/K/M.
  - The IDXW derivation.
  - Elaboration checks for K mod M == 0 and K >= 2.
- One sub-module: the existing argmax (k=M, n=N), instantiated once as the per-chunk datapath. Its lowest-index tie rule is part of its contract and is covered by its own bench.

Test Plan:
- Basic: K=100, M=10; frame of samples -50..49 in order, no backpressure -> out_index_o=99, out_max_o=49, out_valid_o at t+11.
- Signedness: all samples -1 except buf[57]=+3 and buf[12]=8'h80 -> index 57, max 3; a frame with 8'h7F at index 0 -> index 0, max 127.
- Ties: all samples 8'h05 -> index 0; +100 at indices 23 and 81, others random below 100 -> index 23.
- Backpressure:
  - Hold out_ready_i=0 for 20 cycles after out_valid_o -> index and max stable, in_ready_o=0, in_valid_i pulses ignored.
  - Then assert out_ready_i -> out_valid_o=0 and in_ready_o=1 the next cycle; the next frame is correct.
- Abort and reset:
  - clear_i after 37 samples -> no output.
  - clear_i during EVAL at c=4 -> out_valid_o stays 0, state LOAD.
  - rst_ni low mid-DONE -> out_valid_o=0 immediately.
  - In all three cases a following full frame gives the correct result.
- Parameter sweep: M=K=100 (1-cycle EVAL) and M=1 (100-cycle EVAL), 100 random frames each -> zero mismatches against a lowest-index signed reference model.
